// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder at the slave end of the load/store path. It accepts one
// request at a time, inserts WAIT_CYCLES extra cycles, then performs an RV32I
// byte/half/word access with lane steering and sign/zero extension. It returns
// the result, or an error, over a registered valid/ready response channel.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two)
//   WAIT_CYCLES  extra cycles between accept and response (0..15)
//   BASE_ADDR    byte address of word 0 (aligned to DEPTH_WORDS*4)
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we                   1 = store, 0 = load
//   req_funct3               RV32I access size / signedness
//   req_addr, req_wdata      byte address and store data
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata                extended load result (0 for stores and errors)
//   rsp_err                  misaligned, out-of-range or illegal funct3
//
// Optional build macro
//   DMEM_STATS_EN  adds stat_loads / stat_stores / stat_errors response counters
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_errors
`endif
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;

    logic [31:0] mem_r [DEPTH_WORDS];

    logic        acc_we_s;
    logic [2:0]  acc_funct3_s;
    logic [31:0] acc_addr_s;
    logic [31:0] acc_wdata_s;
    logic        to_resp_s;
    logic        illegal_s;
    logic        misalign_s;
    logic        range_err_s;
    logic        err_s;
    logic [3:0]  wmask_s;
    logic [31:0] wlanes_s;
    logic [31:0] off_s;
    logic [31:0] word_off_s;
    logic [AW-1:0] word_idx_s;
    logic [31:0] rd_word_s;
    logic [31:0] resp_rdata_s;

    // Select byte/half/word from a memory word and extend it according to funct3.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // With WAIT_CYCLES=0 the access happens on the accept edge, before the
    // request is latched, so the access operands come straight from req_* in IDLE.
    always_comb begin
        if (state_r == IDLE) begin
            acc_we_s     = req_we;
            acc_funct3_s = req_funct3;
            acc_addr_s   = req_addr;
            acc_wdata_s  = req_wdata;
        end else begin
            acc_we_s     = we_r;
            acc_funct3_s = funct3_r;
            acc_addr_s   = addr_r;
            acc_wdata_s  = wdata_r;
        end
    end

    // Edge on which the access is performed (the transition into RESP).
    always_comb begin
        to_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && (WAIT_CYCLES == 32'd0)) begin
                    to_resp_s = 1'b1;
                end else begin
                    to_resp_s = 1'b0;
                end
            end
            WAIT:    to_resp_s = (cnt_r == 4'd1);
            default: to_resp_s = 1'b0;
        endcase
    end

    // Access decode: legality, alignment, range, store lane mask and lane data.
    always_comb begin
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        wmask_s    = 4'b0000;
        wlanes_s   = 32'd0;
        case (acc_funct3_s)
            3'b000, 3'b100: begin
                wmask_s  = 4'b0001 << acc_addr_s[1:0];
                wlanes_s = {4{acc_wdata_s[7:0]}};
            end
            3'b001, 3'b101: begin
                misalign_s = acc_addr_s[0];
                wmask_s    = acc_addr_s[1] ? 4'b1100 : 4'b0011;
                wlanes_s   = {2{acc_wdata_s[15:0]}};
            end
            3'b010: begin
                misalign_s = |acc_addr_s[1:0];
                wmask_s    = 4'b1111;
                wlanes_s   = acc_wdata_s;
            end
            default: illegal_s = 1'b1;
        endcase
        // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
        off_s        = acc_addr_s - BASE_ADDR;
        word_off_s   = off_s >> 2;
        range_err_s  = (word_off_s >= 32'(DEPTH_WORDS));
        err_s        = illegal_s | misalign_s | range_err_s;
        word_idx_s   = word_off_s[AW-1:0];
        rd_word_s    = mem_r[word_idx_s];
        resp_rdata_s = (err_s || acc_we_s) ? 32'd0
                     : load_extract(acc_funct3_s, acc_addr_s[1:0], rd_word_s);
    end

    // Store commit on entry to RESP; a reset on the same edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && to_resp_s && acc_we_s && !err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_s[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            we_r      <= 1'b0;
            funct3_r  <= 3'd0;
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_r      <= req_we;
                        funct3_r  <= req_funct3;
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        cnt_r     <= 4'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                        if (to_resp_s) begin
                            state_r   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= resp_rdata_s;
                            rsp_err   <= err_s;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    req_ready <= 1'b0;
                    if (to_resp_s) begin
                        state_r   <= RESP;
                        cnt_r     <= 4'd0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= resp_rdata_s;
                        rsp_err   <= err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r   <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= 4'd0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    // Completed-response counters; error responses are counted only as errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads  <= 32'd0;
            stat_stores <= 32'd0;
            stat_errors <= 32'd0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_err) begin
                stat_errors <= stat_errors + 32'd1;
            end else if (we_r) begin
                stat_stores <= stat_stores + 32'd1;
            end else begin
                stat_loads <= stat_loads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder with default parameters
// (DEPTH_WORDS=1024, WAIT_CYCLES=2, BASE_ADDR=0). Expected values are
// hand-computed from the memory contents that the sequence builds up.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int WAIT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_errors;
`endif

    int n_vec;
    int n_fail;
    int exp_loads;
    int exp_stores;
    int exp_errors;

    dmem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
`ifdef DMEM_STATS_EN
        ,
        .stat_loads (stat_loads),
        .stat_stores(stat_stores),
        .stat_errors(stat_errors)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction with rsp_ready held high.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, ".lat"}, 32'(lat), 32'(WAIT));
        check_eq({tag, ".rdata"}, rsp_rdata, exp_rd);
        check_eq({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        if (exp_err) exp_errors++;
        else if (we) exp_stores++;
        else exp_loads++;
        @(posedge clk); #1;
        check_eq({tag, ".done"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int lat;
        n_vec = 0; n_fail = 0;
        exp_loads = 0; exp_stores = 0; exp_errors = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst.rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
`ifdef DMEM_STATS_EN
        check_eq("rst.stat_loads", stat_loads, 32'd0);
        check_eq("rst.stat_stores", stat_stores, 32'd0);
        check_eq("rst.stat_errors", stat_errors, 32'd0);
`endif
        rst = 1'b0;

        // Word store / load
        do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte store to lane 2, then byte/half loads with extension
        do_req("sb12", 1'b1, 3'b000, 32'h12, 32'h0000007F, 32'h0, 1'b0);
        do_req("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        do_req("lb12", 1'b0, 3'b000, 32'h12, 32'h0, 32'h0000007F, 1'b0);
        do_req("lbu12", 1'b0, 3'b100, 32'h12, 32'h0, 32'h0000007F, 1'b0);
        do_req("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDE7F, 1'b0);
        do_req("lh10", 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
        do_req("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);

        // Misaligned and illegal accesses: error, no data, no write
        do_req("lh11", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
        do_req("lw12", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
        do_req("f011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        do_req("sh11", 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req("sw12", 1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req("s111", 1'b1, 3'b111, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDE7FBEEF, 1'b0);

        // Range boundary: last word is legal, one past it aliases word 0 if unchecked
        do_req("sw0", 1'b1, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0);
        do_req("swFFC", 1'b1, 3'b010, 32'hFFC, 32'hA5A50001, 32'h0, 1'b0);
        do_req("lwFFC", 1'b0, 3'b010, 32'hFFC, 32'h0, 32'hA5A50001, 1'b0);
        do_req("sw1000", 1'b1, 3'b010, 32'h1000, 32'h55555555, 32'h0, 1'b1);
        do_req("lw1000", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
        do_req("lwneg", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);
        do_req("lw0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0);

        // Response back-pressure with a competing request held on req_*
        rsp_ready  = 1'b0;
        req_valid  = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr   = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("bp.lat", 32'(lat), 32'(WAIT));
        req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check_eq("bp.rsp_rdata", rsp_rdata, 32'hDE7FBEEF);
            check_eq("bp.rsp_err", {31'd0, rsp_err}, 32'd0);
            check_eq("bp.req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        exp_loads++;
        @(posedge clk); #1;
        check_eq("bp.done", {31'd0, rsp_valid}, 32'd0);
        check_eq("bp.idle", {31'd0, req_ready}, 32'd1);
        do_req("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDE7FBEEF, 1'b0);

        // Reset during WAIT drops the pending store
        do_req("sw20", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr  = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("rw.wait_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_loads = 0; exp_stores = 0; exp_errors = 0;
        check_eq("rw.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rw.req_ready", {31'd0, req_ready}, 32'd1);
`ifdef DMEM_STATS_EN
        check_eq("rw.stat_loads", stat_loads, 32'd0);
        check_eq("rw.stat_stores", stat_stores, 32'd0);
        check_eq("rw.stat_errors", stat_errors, 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("rw.quiet", {31'd0, rsp_valid}, 32'd0);
        do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        do_req("sh16", 1'b1, 3'b001, 32'h16, 32'h00008001, 32'h0, 1'b0);
        do_req("lh16", 1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8001, 1'b0);
        do_req("lbu17", 1'b0, 3'b100, 32'h17, 32'h0, 32'h00000080, 1'b0);
        do_req("lw14e", 1'b0, 3'b010, 32'h15, 32'h0, 32'h0, 1'b1);

`ifdef DMEM_STATS_EN
        check_eq("end.stat_loads", stat_loads, 32'(exp_loads));
        check_eq("end.stat_stores", stat_stores, 32'(exp_stores));
        check_eq("end.stat_errors", stat_errors, 32'(exp_errors));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
